// File: rtl/play_step_scheduler.sv
// Gameplay step scheduler: paces step requests to the game datapath with a
// req/ack handshake. It raises the difficulty level every STEPS_PER_LEVEL
// acknowledged steps, runs the round timer and flags timeout when the round
// runs out. Expects BASE_PERIOD >= MIN_PERIOD >= 1, MAX_LEVEL < 16 and
// ROUND_SECONDS <= 99.
// Optional feature: define SCHED_LEVEL_BONUS_EN to add 5 seconds (saturating
// at ROUND_SECONDS) to the round clock on every actual level increment.
module play_step_scheduler #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned PERIOD_DEC      = 2_000_000,
  parameter int unsigned MIN_PERIOD      = 5_000_000,
  parameter int unsigned STEPS_PER_LEVEL = 16,
  parameter int unsigned MAX_LEVEL       = 9,
  parameter int unsigned ROUND_SECONDS   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_state,
  input  logic       pause_req,
  input  logic       step_ack,
  output logic       step_req,
  output logic [3:0] level,
  output logic [6:0] time_left,
  output logic       paused,
  output logic       timeout
);

  localparam logic [1:0]  GAME_PLAY = 2'd2;
  localparam int unsigned PW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam int unsigned SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned CW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_RUN,
    S_WAIT_ACK,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] period_ctr, period_ctr_nxt;
  logic [SW-1:0] sec_ctr, sec_ctr_nxt;
  logic [CW-1:0] step_count, step_count_nxt;
  logic [3:0]    level_nxt;
  logic [6:0]    time_left_nxt;
  logic          step_req_nxt, paused_nxt, timeout_nxt;
  logic          pause_pend, pause_pend_nxt;

  logic [31:0]   level_dec, cur_period;
  logic          period_end, sec_end, count_end, level_max;
  logic          level_up;
  logic [6:0]    tl_next;

  // Step period for the current level, floored at MIN_PERIOD; the compare
  // happens before the subtraction so the unsigned result cannot wrap.
  always_comb begin
    level_dec = 32'(level) * PERIOD_DEC;
    if (level_dec >= BASE_PERIOD - MIN_PERIOD) cur_period = MIN_PERIOD;
    else                                        cur_period = BASE_PERIOD - level_dec;
  end

  assign period_end = (32'(period_ctr) == cur_period - 32'd1);
  assign sec_end    = (sec_ctr == SW'(CLK_HZ - 1));
  assign count_end  = (step_count == CW'(STEPS_PER_LEVEL - 1));
  assign level_max  = (level == 4'(MAX_LEVEL));

  // Next-state and next-output logic for the scheduler FSM and its counters.
  always_comb begin
    // NOTE: every next value gets a default first, so no path through this block can infer a latch.
    state_nxt      = state;
    period_ctr_nxt = period_ctr;
    sec_ctr_nxt    = sec_ctr;
    step_count_nxt = step_count;
    level_nxt      = level;
    time_left_nxt  = time_left;
    step_req_nxt   = step_req;
    paused_nxt     = paused;
    timeout_nxt    = timeout;
    pause_pend_nxt = pause_pend;
    level_up       = 1'b0;
    tl_next        = time_left;

    if (game_state != GAME_PLAY) begin
      // Leaving PLAY abandons any outstanding step and restores reset values.
      state_nxt      = S_OFF;
      period_ctr_nxt = '0;
      sec_ctr_nxt    = '0;
      step_count_nxt = '0;
      level_nxt      = '0;
      time_left_nxt  = 7'(ROUND_SECONDS);
      step_req_nxt   = 1'b0;
      paused_nxt     = 1'b0;
      timeout_nxt    = 1'b0;
      pause_pend_nxt = 1'b0;
    end else begin
      case (state)
        S_OFF: state_nxt = S_RUN;

        S_RUN: begin
          // A pause on the terminal edge wins; the frozen counter fires on resume.
          if (pause_req) begin
            state_nxt  = S_PAUSE;
            paused_nxt = 1'b1;
          end else if (period_end) begin
            period_ctr_nxt = '0;
            step_req_nxt   = 1'b1;
            state_nxt      = S_WAIT_ACK;
          end else begin
            period_ctr_nxt = period_ctr + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (step_ack) begin
            step_req_nxt = 1'b0;
            if (count_end) begin
              step_count_nxt = '0;
              level_up       = !level_max;
              if (!level_max) level_nxt = level + 4'd1;
            end else begin
              step_count_nxt = step_count + 1'b1;
            end
            if (pause_pend || pause_req) begin
              state_nxt      = S_PAUSE;
              paused_nxt     = 1'b1;
              pause_pend_nxt = 1'b0;
            end else begin
              state_nxt = S_RUN;
            end
          end else if (pause_req) begin
            pause_pend_nxt = 1'b1;
          end
        end

        S_PAUSE: begin
          if (pause_req) begin
            state_nxt  = S_RUN;
            paused_nxt = 1'b0;
          end
        end

        default: begin
          // S_DONE: everything holds until the top FSM leaves PLAY.
        end
      endcase

      // The round clock only runs while gameplay is live.
      if (state == S_RUN || state == S_WAIT_ACK) begin
        if (sec_end) begin
          sec_ctr_nxt = '0;
          tl_next     = time_left - 7'd1;
        end else begin
          sec_ctr_nxt = sec_ctr + 1'b1;
        end
`ifdef SCHED_LEVEL_BONUS_EN
        if (level_up) begin
          tl_next = (tl_next + 7'd5 > 7'(ROUND_SECONDS)) ? 7'(ROUND_SECONDS) : tl_next + 7'd5;
        end
`endif
        time_left_nxt = tl_next;
        if (sec_end && tl_next == 7'd0) begin
          state_nxt      = S_DONE;
          timeout_nxt    = 1'b1;
          step_req_nxt   = 1'b0;
          paused_nxt     = 1'b0;
          pause_pend_nxt = 1'b0;
        end
      end
    end
  end

  // State, counter and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (!rst) begin
      state      <= S_OFF;
      period_ctr <= '0;
      sec_ctr    <= '0;
      step_count <= '0;
      level      <= '0;
      time_left  <= 7'(ROUND_SECONDS);
      step_req   <= 1'b0;
      paused     <= 1'b0;
      timeout    <= 1'b0;
      pause_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_ctr <= period_ctr_nxt;
      sec_ctr    <= sec_ctr_nxt;
      step_count <= step_count_nxt;
      level      <= level_nxt;
      time_left  <= time_left_nxt;
      step_req   <= step_req_nxt;
      paused     <= paused_nxt;
      timeout    <= timeout_nxt;
      pause_pend <= pause_pend_nxt;
    end
  end

endmodule

// File: tb/tb_play_step_scheduler.sv
// Self-checking bench for play_step_scheduler with small parameters.
// A behavioural model (countdowns, total ack count, level derived from it)
// predicts every output after every edge; directed scenarios add fixed
// expectations for step timing, level changes, the round timer and pausing.
module tb_play_step_scheduler;

  localparam int CLK_HZ = 20;
  localparam int BASE   = 10;
  localparam int DEC    = 2;
  localparam int MINP   = 4;
  localparam int SPL    = 2;
  localparam int MAXL   = 3;
  localparam int ROUND  = 3;
  localparam logic [1:0] PLAY = 2'd2;
`ifdef SCHED_LEVEL_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] game_state = 2'd0;
  logic       pause_req = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req, paused, timeout;
  logic [3:0] level;
  logic [6:0] time_left;
  // Second instance with a longer round, used to reach level saturation.
  logic       lg_step_req, lg_paused, lg_timeout;
  logic [3:0] lg_level;
  logic [6:0] lg_time_left;

  play_step_scheduler #(
    .CLK_HZ(CLK_HZ), .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP),
    .STEPS_PER_LEVEL(SPL), .MAX_LEVEL(MAXL), .ROUND_SECONDS(ROUND)
  ) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .pause_req(pause_req),
    .step_ack(step_ack), .step_req(step_req), .level(level),
    .time_left(time_left), .paused(paused), .timeout(timeout)
  );

  play_step_scheduler #(
    .CLK_HZ(CLK_HZ), .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP),
    .STEPS_PER_LEVEL(SPL), .MAX_LEVEL(MAXL), .ROUND_SECONDS(9)
  ) dut_long (
    .clk(clk), .rst(rst), .game_state(game_state), .pause_req(pause_req),
    .step_ack(step_ack), .step_req(lg_step_req), .level(lg_level),
    .time_left(lg_time_left), .paused(lg_paused), .timeout(lg_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  // Behavioural model state.
  bit m_on, m_wait, m_pause, m_done, m_pend;
  int m_count, m_sec, m_time, m_acks;

  function automatic int lvl_of(input int acks);
    int l;
    l = acks / SPL;
    return (l > MAXL) ? MAXL : l;
  endfunction

  function automatic int period_of(input int l);
    int p;
    p = BASE - l * DEC;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_on = 0; m_wait = 0; m_pause = 0; m_done = 0; m_pend = 0;
    m_count = 0; m_sec = 0; m_time = ROUND; m_acks = 0;
  endtask

  task automatic model_edge(input logic [1:0] gs, input bit pr, input bit ack);
    bit bonus;
    bit tick;
    int old_lvl;
    bonus = 0;
    if (gs != PLAY) begin
      model_reset();
    end else if (!m_on) begin
      m_on = 1; m_count = period_of(0); m_sec = CLK_HZ;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_pause) begin
      if (pr) m_pause = 0;
    end else begin
      if (m_wait) begin
        if (ack) begin
          old_lvl = lvl_of(m_acks);
          m_acks++;
          bonus = lvl_of(m_acks) > old_lvl;
          m_wait = 0;
          m_count = period_of(lvl_of(m_acks));
          if (m_pend || pr) begin m_pause = 1; m_pend = 0; end
        end else if (pr) begin
          m_pend = 1;
        end
      end else if (pr) begin
        m_pause = 1;
      end else begin
        m_count--;
        if (m_count == 0) m_wait = 1;
      end
      m_sec--;
      tick = (m_sec == 0);
      if (tick) begin m_sec = CLK_HZ; m_time--; end
      if (bonus && BONUS_EN) m_time = (m_time + 5 > ROUND) ? ROUND : m_time + 5;
      if (tick && m_time == 0) begin m_done = 1; m_wait = 0; m_pause = 0; m_pend = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic check_all();
    check("step_req",  32'(step_req),  32'(m_wait));
    check("level",     32'(level),     32'(lvl_of(m_acks)));
    check("time_left", 32'(time_left), 32'(m_time));
    check("paused",    32'(paused),    32'(m_pause));
    check("timeout",   32'(timeout),   32'(m_done));
  endtask

  // One clock edge: drive inputs, advance the model, sample 1 time unit later.
  task automatic step(input logic [1:0] gs, input bit pr, input bit ack);
    game_state = gs; pause_req = pr; step_ack = ack;
    @(posedge clk);
    model_edge(gs, pr, ack);
    edge_no++;
    #1;
    check_all();
  endtask

  // Bounded wait for step_req; checks the number of edges it took.
  task automatic wait_rise(input string tag, input int exp_gap);
    int n;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step(PLAY, 1'b0, 1'b0);
      if (step_req === 1'b1) begin n = i; break; end
    end
    check(tag, 32'(n), 32'(exp_gap));
  endtask

  initial begin
    int rises[$];
    int lg_rises[$];
    int tl_edges[$];
    int exp_rise[9];
    logic prev_req, prev_lg, ack;
    logic [6:0] prev_tl, held_tl;
    logic [1:0] gs;
    bit pr;

    exp_rise = '{10, 21, 30, 39, 46, 53, 58, 63, 68};

    // Reset values while rst is held low.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Scenarios 1-3: auto-ack one cycle after each request, full round.
    edge_no = -1;
    prev_req = 1'b0; prev_lg = 1'b0; prev_tl = 7'(ROUND);
    for (int i = 0; i <= 70; i++) begin
      ack = m_wait || lg_step_req;
      step(PLAY, 1'b0, ack);
      if (step_req === 1'b1 && prev_req === 1'b0) rises.push_back(edge_no);
      if (lg_step_req === 1'b1 && prev_lg === 1'b0) lg_rises.push_back(edge_no);
      if (time_left !== prev_tl) tl_edges.push_back(edge_no);
      prev_req = step_req; prev_lg = lg_step_req; prev_tl = time_left;
      case (edge_no)
        11: check("s1_ack_drops_req", 32'(step_req), 32'd0);
        21: check("s2_level_before", 32'(level), 32'd0);
        22: check("s2_level1", 32'(level), 32'd1);
        40: check("s2_level2", 32'(level), 32'd2);
        54: check("s2_level3", 32'(level), 32'd3);
        59: check("s3_no_timeout_yet", 32'(timeout), 32'd0);
        60: check("s3_timeout_edge", 32'(timeout), 32'd1);
        default: ;
      endcase
    end
    check("s1_rise_count", 32'(rises.size()), 32'd7);
    foreach (rises[k]) if (k < 7) check("s1_rise_edge", 32'(rises[k]), 32'(exp_rise[k]));
    check("s2_long_rise_count", 32'(lg_rises.size()), 32'd9);
    foreach (lg_rises[k]) if (k < 9) check("s2_long_rise_edge", 32'(lg_rises[k]), 32'(exp_rise[k]));
    check("s2_long_level_sat", 32'(lg_level), 32'd3);
    check("s2_long_time_left", 32'(lg_time_left), 32'd6);
    check("s2_long_paused", 32'(lg_paused), 32'd0);
    check("s2_long_timeout", 32'(lg_timeout), 32'd0);
    check("s3_tick_count", 32'(tl_edges.size()), 32'd3);
    foreach (tl_edges[k]) if (k < 3) check("s3_tick_edge", 32'(tl_edges[k]), 32'(20 * (k + 1)));
    check("s3_done_req", 32'(step_req), 32'd0);
    check("s3_done_time", 32'(time_left), 32'd0);
    for (int i = 0; i < 5; i++) step(PLAY, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("s3_held_timeout", 32'(timeout), 32'd1);
    step(2'd0, 1'b0, 1'b0);
    check("s3_exit_timeout", 32'(timeout), 32'd0);
    check("s3_exit_time", 32'(time_left), 32'd3);

    // Scenario 4: pause requested while a step is outstanding.
    edge_no = -1;
    step(PLAY, 1'b0, 1'b0);
    wait_rise("s4_first_step", 10);
    step(PLAY, 1'b1, 1'b0);
    check("s4_req_held", 32'(step_req), 32'd1);
    check("s4_not_paused", 32'(paused), 32'd0);
    step(PLAY, 1'b0, 1'b1);
    check("s4_paused_after_ack", 32'(paused), 32'd1);
    held_tl = time_left;
    for (int i = 0; i < 30; i++) step(PLAY, 1'b0, 1'b0);
    check("s4_still_paused", 32'(paused), 32'd1);
    check("s4_time_frozen", 32'(time_left), 32'(held_tl));
    step(PLAY, 1'b1, 1'b0);
    check("s4_resumed", 32'(paused), 32'd0);
    wait_rise("s4_resume_gap", 10);

    // Scenario 5: leave PLAY with a step outstanding, then re-enter.
    step(2'd0, 1'b0, 1'b0);
    check("s5_req_abandoned", 32'(step_req), 32'd0);
    check("s5_level_cleared", 32'(level), 32'd0);
    check("s5_time_restored", 32'(time_left), 32'd3);
    step(2'd0, 1'b0, 1'b1);
    edge_no = -1;
    step(PLAY, 1'b0, 1'b1);
    step(PLAY, 1'b0, 1'b1);
    wait_rise("s5_reentry_gap", 9);

    // Scenario 6: reach level 1 while one second is left.
    step(PLAY, 1'b0, 1'b1);
    while (edge_no < 44) step(PLAY, 1'b0, 1'b0);
    check("s6_waiting", 32'(step_req), 32'd1);
    check("s6_time_one", 32'(time_left), 32'd1);
    step(PLAY, 1'b0, 1'b1);
    check("s6_level1", 32'(level), 32'd1);
    check("s6_time_after_level", 32'(time_left), BONUS_EN ? 32'd3 : 32'd1);

    // Random traffic against the model, with one asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      gs = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(0, 1) * 3) : PLAY;
      pr = ($urandom_range(0, 15) == 0);
      ack = m_wait ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      if (pr) ack = 1'b0;
      step(gs, pr, ack);
      if (i == 1500) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
